// File: rtl/acc_datapath_if.sv
// Strobe/program-load/debug bundle between the fetch-execute sequencer and acc_datapath.
interface acc_datapath_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          MRd, ld_pc, Inc_pc, ld_IR, Ld_acc, ALU_setup, Mwr;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic [AW-1:0] pc_o;
    logic [DW-1:0] ir_o;
    logic [DW-1:0] acc_o;
    logic          zero, carry, halted, err;

    modport slave (
        input  MRd, ld_pc, Inc_pc, ld_IR, Ld_acc, ALU_setup, Mwr,
        input  prog_we, prog_addr, prog_data,
        output pc_o, ir_o, acc_o, zero, carry, halted, err
    );
    modport master (
        output MRd, ld_pc, Inc_pc, ld_IR, Ld_acc, ALU_setup, Mwr,
        output prog_we, prog_addr, prog_data,
        input  pc_o, ir_o, acc_o, zero, carry, halted, err
    );
endinterface

// File: rtl/acc_datapath.sv
// Accumulator datapath: executes one-hot sequencer strobes against PC/MDR/IR/OPR/ACC
// and an internal program/data memory with a program-load write port.
module acc_datapath #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           rst,
    acc_datapath_if.slave  bus
);
    localparam logic [3:0] OP_LDA = 4'h1, OP_LDI = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                           OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7, OP_NOT = 4'h8,
                           OP_SHL = 4'h9, OP_SHR = 4'hA, OP_STA = 4'hB, OP_JMP = 4'hC,
                           OP_JZ  = 4'hD, OP_HLT = 4'hE;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] mdr_q, mdr_d, ir_q, ir_d, opr_q, opr_d, acc_q, acc_d;
    logic          zero_q, zero_d, carry_q, carry_d;
    logic          halted_q, halted_d, err_q, err_d, jumped_q, jumped_d;

    logic [6:0]    strb;
    logic          multi, go, upd_zero;
    logic [3:0]    mdr_op, ir_op;
    logic [AW-1:0] ir_addr;
    logic [DW:0]   sum;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    assign mdr_op  = mdr_q[DW-1:DW-4];
    assign ir_op   = ir_q[DW-1:DW-4];
    assign ir_addr = ir_q[AW-1:0];

    always_comb begin
        strb     = {bus.MRd, bus.ld_pc, bus.Inc_pc, bus.ld_IR, bus.Ld_acc, bus.ALU_setup, bus.Mwr};
        // More than one bit set: clearing the lowest set bit leaves something behind.
        multi    = |(strb & (strb - 7'd1));
        go       = !halted_q && !multi;
        sum      = {1'b0, acc_q} + {1'b0, opr_q};
        pc_d     = pc_q;
        mdr_d    = mdr_q;
        ir_d     = ir_q;
        opr_d    = opr_q;
        acc_d    = acc_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        halted_d = halted_q;
        jumped_d = jumped_q;
        err_d    = err_q | (!halted_q && multi);
        upd_zero = 1'b0;
        mem_we   = 1'b0;
        mem_wa   = ir_addr;
        mem_wd   = acc_q;

        if (go && bus.MRd) begin
            mdr_d    = mem[pc_q];
            jumped_d = 1'b0;
        end
        if (go && bus.ld_pc) begin
            if (mdr_op == OP_JMP || (mdr_op == OP_JZ && zero_q)) begin
                pc_d     = mdr_q[AW-1:0];
                jumped_d = 1'b1;
            end
        end
        if (go && bus.Inc_pc) begin
            if (jumped_q) jumped_d = 1'b0;
            else          pc_d     = pc_q + AW'(1);
        end
        if (go && bus.ld_IR) ir_d = mdr_q;
        if (go && bus.Ld_acc) opr_d = (ir_op == OP_LDI) ? {4'b0, ir_q[DW-5:0]} : mem[ir_addr];
        if (go && bus.ALU_setup) begin
            case (ir_op)
                OP_LDA, OP_LDI: begin acc_d = opr_q; upd_zero = 1'b1; end
                OP_ADD: begin {carry_d, acc_d} = sum; upd_zero = 1'b1; end
                OP_SUB: begin acc_d = acc_q - opr_q; carry_d = acc_q < opr_q; upd_zero = 1'b1; end
                OP_AND: begin acc_d = acc_q & opr_q; carry_d = 1'b0; upd_zero = 1'b1; end
                OP_OR:  begin acc_d = acc_q | opr_q; carry_d = 1'b0; upd_zero = 1'b1; end
                OP_XOR: begin acc_d = acc_q ^ opr_q; carry_d = 1'b0; upd_zero = 1'b1; end
                OP_NOT: begin acc_d = ~acc_q; carry_d = 1'b0; upd_zero = 1'b1; end
                OP_SHL: begin acc_d = acc_q << 1; carry_d = acc_q[DW-1]; upd_zero = 1'b1; end
                OP_SHR: begin acc_d = acc_q >> 1; carry_d = acc_q[0]; upd_zero = 1'b1; end
                OP_HLT: halted_d = 1'b1;
                default: ;
            endcase
            if (upd_zero) zero_d = (acc_d == '0);
        end
        // Program load owns the write port; a colliding STA write is silently dropped.
        if (bus.prog_we) begin
            mem_we = 1'b1;
            mem_wa = bus.prog_addr;
            mem_wd = bus.prog_data;
        end else if (go && bus.Mwr && ir_op == OP_STA) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            mdr_q    <= '0;
            ir_q     <= '0;
            opr_q    <= '0;
            acc_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            jumped_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            mdr_q    <= mdr_d;
            ir_q     <= ir_d;
            opr_q    <= opr_d;
            acc_q    <= acc_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            jumped_q <= jumped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign bus.pc_o   = pc_q;
    assign bus.ir_o   = ir_q;
    assign bus.acc_o  = acc_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;
    assign bus.halted = halted_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_acc_datapath.sv
// Directed bench for acc_datapath: expectations queued ahead of each step, checked after it.
module tb_acc_datapath;
    localparam int AW = 8, DW = 32;
    localparam logic [6:0] S_MRD = 7'b1000000, S_LDPC = 7'b0100000, S_INC = 7'b0010000,
                           S_LDIR = 7'b0001000, S_LDACC = 7'b0000100, S_ALU = 7'b0000010,
                           S_MWR = 7'b0000001;
    localparam int P_PC = 0, P_IR = 1, P_ACC = 2, P_Z = 3, P_C = 4, P_H = 5, P_E = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    acc_datapath_if #(.AW(AW), .DW(DW)) bus ();
    acc_datapath #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string         tag;
        int            sel;
        logic [DW-1:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [DW-1:0] obs(int sel);
        case (sel)
            P_PC:    return DW'(bus.pc_o);
            P_IR:    return bus.ir_o;
            P_ACC:   return bus.acc_o;
            P_Z:     return DW'(bus.zero);
            P_C:     return DW'(bus.carry);
            P_H:     return DW'(bus.halted);
            default: return DW'(bus.err);
        endcase
    endfunction

    task automatic push(string tag, int sel, logic [DW-1:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.v = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e;
            logic [DW-1:0] o;
            e = sb.pop_front();
            o = obs(e.sel);
            n_vec++;
            assert (o === e.v) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
            end
        end
    endtask

    task automatic step_nd(logic [6:0] s);
        {bus.MRd, bus.ld_pc, bus.Inc_pc, bus.ld_IR, bus.Ld_acc, bus.ALU_setup, bus.Mwr} = s;
        @(negedge clk);
        {bus.MRd, bus.ld_pc, bus.Inc_pc, bus.ld_IR, bus.Ld_acc, bus.ALU_setup, bus.Mwr} = '0;
    endtask

    task automatic step(logic [6:0] s);
        step_nd(s);
        drain();
    endtask

    task automatic instr();
        step_nd(S_MRD); step_nd(S_LDPC); step_nd(S_INC); step_nd(S_LDIR);
        step_nd(S_LDACC); step_nd(S_ALU); step_nd(S_MWR);
        drain();
    endtask

    task automatic pload(logic [AW-1:0] a, logic [DW-1:0] d);
        bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    task automatic reset_checks(string tag);
        push({tag, "_pc"}, P_PC, 0);   push({tag, "_ir"}, P_IR, 0);
        push({tag, "_acc"}, P_ACC, 0); push({tag, "_z"}, P_Z, 0);
        push({tag, "_c"}, P_C, 0);     push({tag, "_h"}, P_H, 0);
        push({tag, "_e"}, P_E, 0);
        drain();
    endtask

    initial begin
        {bus.MRd, bus.ld_pc, bus.Inc_pc, bus.ld_IR, bus.Ld_acc, bus.ALU_setup, bus.Mwr} = '0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        @(negedge clk);
        reset_checks("por");
        rst = 1'b1;
        @(negedge clk);

        pload(8'h00, 32'h20000005); pload(8'h01, 32'h30000010); pload(8'h10, 32'hFFFFFFFB);
        pload(8'h02, 32'hD0000040); pload(8'h40, 32'h20000007); pload(8'h41, 32'hB0000020);
        pload(8'h42, 32'hD0000040); pload(8'h43, 32'h20000003); pload(8'h44, 32'h40000020);
        pload(8'h45, 32'h10000020); pload(8'h46, 32'hC00000FF); pload(8'hFF, 32'h10000030);
        pload(8'h30, 32'h80000001); pload(8'h03, 32'h20000009);

        // LDI 5 then ADD 0xFFFFFFFB -> wraps to zero with carry out
        push("ldi_acc", P_ACC, 5); push("ldi_pc", P_PC, 1); push("ldi_z", P_Z, 0);
        instr();
        push("add_acc", P_ACC, 0); push("add_z", P_Z, 1); push("add_c", P_C, 1);
        push("add_pc", P_PC, 2); push("add_ir", P_IR, 32'h30000010);
        instr();

        // JZ taken
        step(S_MRD);
        push("jz_t_ldpc", P_PC, 32'h40); step(S_LDPC);
        push("jz_t_inc", P_PC, 32'h40); step(S_INC);
        step(S_LDIR); step(S_LDACC); step(S_ALU);
        push("jz_t_acc", P_ACC, 0); push("jz_t_z", P_Z, 1); step(S_MWR);

        push("ldi7_acc", P_ACC, 7); push("ldi7_pc", P_PC, 32'h41); instr();
        push("sta_pc", P_PC, 32'h42); push("sta_acc", P_ACC, 7); instr();

        // JZ not taken (zero=0)
        step(S_MRD);
        push("jz_n_ldpc", P_PC, 32'h42); step(S_LDPC);
        push("jz_n_inc", P_PC, 32'h43); step(S_INC);
        step(S_LDIR); step(S_LDACC); step(S_ALU); step(S_MWR);

        push("ldi3_acc", P_ACC, 3); instr();
        push("sub_acc", P_ACC, 32'hFFFFFFFC); push("sub_c", P_C, 1); push("sub_z", P_Z, 0);
        instr();
        push("lda_st_acc", P_ACC, 7); push("lda_c_kept", P_C, 1); instr();

        // JMP 0xFF, then PC wrap
        push("jmp_pc", P_PC, 32'hFF); instr();
        pload(8'h00, 32'h90000000); pload(8'h01, 32'hA0000000); pload(8'h02, 32'hE0000000);
        step(S_MRD); step(S_LDPC);
        push("wrap_pc", P_PC, 0); step(S_INC);
        step(S_LDIR); step(S_LDACC); step(S_ALU); step(S_MWR);
        push("lda30_acc", P_ACC, 32'h80000001);
        drain();
        push("shl_acc", P_ACC, 2); push("shl_c", P_C, 1); push("shl_pc", P_PC, 1); instr();
        push("shr_acc", P_ACC, 1); push("shr_c", P_C, 0); push("shr_z", P_Z, 0); instr();

        // Strobe conflict
        push("cfl_err", P_E, 1); push("cfl_pc", P_PC, 2);
        push("cfl_ir", P_IR, 32'hA0000000); push("cfl_acc", P_ACC, 1);
        step(S_MRD | S_LDIR);

        // HLT, then strobes ignored, program load still live
        push("hlt_h", P_H, 1); push("hlt_pc", P_PC, 3); instr();
        push("hlt_ign_pc", P_PC, 3); push("hlt_ign_acc", P_ACC, 1);
        push("hlt_ign_ir", P_IR, 32'hE0000000);
        instr();
        pload(8'h50, 32'h12345678); pload(8'h00, 32'h10000050);
        pload(8'h01, 32'h20001234); pload(8'h02, 32'hC0000060);

        #2 rst = 1'b0;
        #1 reset_checks("rst1");
        @(negedge clk) rst = 1'b1;
        push("ld_halted_acc", P_ACC, 32'h12345678); push("ld_halted_pc", P_PC, 1); instr();
        push("ldi1234_acc", P_ACC, 32'h1234); instr();

        // Reset mid-instruction with a pending jump
        step(S_MRD);
        push("jmp60_pc", P_PC, 32'h60); step(S_LDPC);
        #2 rst = 1'b0;
        #1 reset_checks("rst2");
        @(negedge clk) rst = 1'b1;
        push("post_rst_acc", P_ACC, 32'h12345678); push("post_rst_pc", P_PC, 1);
        push("post_rst_ir", P_IR, 32'h10000050);
        instr();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/acc_datapath.md
# acc_datapath

Execution end of the processor's control-strobe interface. It consumes the one-hot strobes issued by the fetch/execute sequencer (MRd, ld_pc, Inc_pc, ld_IR, Ld_acc, ALU_setup, Mwr) and performs the matching register transfers. It holds the internal program/data memory, PC, MDR, IR, operand register, accumulator, ALU and flags, and it exposes architectural state for debug and verification.

## Interface
- AW, 8, memory address width; depth = 2^AW words; PC width = AW
- DW, 32, data/instruction width; opcode = bits [DW-1:DW-4], address/immediate field = bits [DW-5:0]
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- MRd, ld_pc, Inc_pc, ld_IR, Ld_acc, ALU_setup, Mwr  in  1 each  sequencer strobes, sampled at rising edge
- prog_we  in  1  program-load write enable
- prog_addr  in  AW  program-load address
- prog_data  in  DW  program-load data
- pc_o  out  AW  program counter
- ir_o  out  DW  instruction register
- acc_o  out  DW  accumulator
- zero  out  1  acc == 0 after last flag-updating op
- carry  out  1  carry/borrow/shift-out of last flag-updating op
- halted  out  1  HLT executed, sticky
- err  out  1  more than one strobe in one cycle, sticky

## Operation
- Opcodes: 0 NOP, 1 LDA, 2 LDI, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 SHL, A SHR, B STA, C JMP, D JZ, E HLT, F NOP. The effective address is the low AW bits of the field. The LDI immediate is the field zero-extended to DW.
- MRd: MDR <= mem[PC]; jumped <= 0.
- ld_pc: if MDR opcode is JMP, or is JZ with zero==1, then PC <= MDR address field and jumped <= 1. Otherwise no change.
- Inc_pc: if jumped, clear jumped and leave PC unchanged. Otherwise PC <= PC+1, wrapping from 2^AW-1 to 0.
- ld_IR: IR <= MDR.
- Ld_acc: OPR <= immediate for LDI, otherwise OPR <= mem[IR addr].
- ALU_setup, by IR opcode:
  - LDA and LDI: acc <= OPR. Update zero. Carry unchanged.
  - ADD: {carry,acc} <= acc+OPR, computed DW+1 wide.
  - SUB: acc <= acc-OPR mod 2^DW. carry <= (acc < OPR), unsigned borrow.
  - AND, OR, XOR: acc <= acc op OPR. carry <= 0.
  - NOT: acc <= ~acc. carry <= 0.
  - SHL: acc <= acc<<1. carry <= old acc[DW-1].
  - SHR: acc <= acc>>1, logical. carry <= old acc[0].
  - All of the ops above update zero from the new acc.
  - HLT: halted <= 1.
  - Any other opcode: no change.
- Mwr: if IR opcode is STA, mem[IR addr] <= acc. Otherwise no effect.
- Strobe conflict: if two or more strobes are high in one cycle, err <= 1 and no strobe action is taken that cycle.
- Halted: all strobes are ignored, with no err update. prog_we still operates. Only reset clears halted.
- prog_we: mem[prog_addr] <= prog_data. It has priority over a same-cycle Mwr, which is dropped with no err. A same-cycle non-Mwr strobe still executes.
- Memory is not reset.

## Timing
- Reset values, asserted asynchronously: pc_o=0, ir_o=0, acc_o=0, MDR=0, OPR=0, zero=0, carry=0, halted=0, err=0, jumped=0.
- Every strobe action is visible on the outputs immediately after the rising edge at which the strobe is sampled high, i.e. 1-cycle latency.
- Memory reads are combinational into the register captured at that edge. A write at edge N is visible to a read at edge N+1.
- The nominal instruction takes 7 strobe cycles: MRd, ld_pc, Inc_pc, ld_IR, Ld_acc, ALU_setup, Mwr. Idle cycles between strobes are allowed and hold state.
- Reset asserted mid-instruction aborts the instruction. Partially loaded MDR/OPR are discarded and any pending jump is forgotten.
- Reset release is taken synchronously at the next edge with no glitch on the outputs.

## Test plan
- Reset: assert rst=0 mid-sequence with acc=0x1234 -> all outputs 0 immediately, before the next clock edge. After release, the first MRd reads mem[0].
- Load and add: program mem[0]=LDI 5 (0x20000005) and mem[1]=ADD 0x10 (0x30000010), with mem[0x10]=0xFFFFFFFB. Run two full 7-strobe sequences -> acc=0, zero=1, carry=1, pc_o=2.
- Jump: JZ 0x40 with zero=1 -> pc_o=0x40 after ld_pc and unchanged after Inc_pc. Same instruction with zero=0 -> pc_o increments by 1.
- Store, then SUB borrow: STA 0x20 with acc=7 -> mem[0x20]=7. Then SUB 0x20 with acc=3 -> acc=0xFFFFFFFC, carry=1, zero=0.
- Wrap and shift: PC=0xFF with Inc_pc -> pc_o=0. SHL with acc=0x80000001 -> acc=0x00000002, carry=1.
- Conflict and halt: MRd and ld_IR high together -> err=1 and no register changes. Execute HLT -> halted=1, later strobes ignored, prog_we still writes memory.
